vga_copper: RTL and testbench

Raster-effect sequencer for `vga_core`. It holds a small command program loaded over a Wishbone slave port. It executes the program as a Wishbone master, issuing register writes to `vga_core` (base `0x04xxxxxx`). Writes to `vga_core` offset `0x18` stall until the raster condition is met, so programs synchronise colour and background changes to beam position without CPU involvement.

---
 rtl/vga_copper_pkg.sv | 26 ++
 rtl/vga_copper_ram.sv | 28 ++
 rtl/vga_copper.sv | 246 ++++++++++++++++++++++++
 tb/tb_vga_copper.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_copper_pkg.sv
// vga_copper shared definitions: opcodes, FSM states, register map.
// Optional feature macro: VGA_COPPER_TIMEOUT_EN (see vga_copper.sv).
package vga_copper_pkg;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_END   = 2'b01;
   localparam logic [1:0] OP_JUMP  = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_BUS
   } state_t;

   localparam logic [7:0] REG_CTRL   = 8'h00;
   localparam logic [7:0] REG_STATUS = 8'h04;
   localparam logic [7:0] REG_PADDR  = 8'h08;
   localparam logic [7:0] REG_PHI    = 8'h0C;
   localparam logic [7:0] REG_PLO    = 8'h10;

   localparam logic [7:0] VGA_CORE_BASE = 8'h04;
   localparam logic [7:0] COPPER_BASE   = 8'h05;

endpackage

// File: rtl/vga_copper_ram.sv
// Program store for vga_copper: one write port, one registered
// read port; a same-address write and read return the old word.
module vga_copper_ram
   import vga_copper_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [39:0]              i_wdata,
   input  logic                     i_re,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [39:0]              o_rdata
);

   logic [39:0] r_mem [DEPTH];
   logic [39:0] r_rdata;

   // read-first storage: the read samples the array before the write lands
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_copper.sv
// Raster-effect sequencer: Wishbone-loaded program replayed as vga_core writes.
// Optional feature macro: VGA_COPPER_TIMEOUT_EN (bus-wait abort with err flag).
module vga_copper
   import vga_copper_pkg::*;
#(
   parameter int PROG_DEPTH     = 64,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_addr_i,
   input  logic [31:0] wb_data_i,
   output logic [31:0] wb_data_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_data_o,
   output logic [3:0]  m_sel_o,
   output logic        m_we_o,
   output logic        m_stb_o,
   output logic        m_cyc_o,
   input  logic        m_ack_i
);

   localparam int AW = $clog2(PROG_DEPTH);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [AW-1:0] r_pc;
   logic [AW-1:0] w_pc_nxt;
   logic [AW-1:0] r_paddr;
   logic [7:0]    r_phi;
   logic          r_run;
   logic          r_loop;
   logic          r_start;
   logic          r_wb_ack;
   logic [31:0]   r_wb_data;
   logic [5:0]    r_m_off;
   logic [31:0]   r_m_data;

   logic [39:0]   w_rd;
   logic [31:0]   w_rdata;
   logic [7:0]    w_off;
   logic [7:0]    w_pc8;
   logic          w_acc;
   logic          w_wr;
   logic          w_ctrl_wr;
   logic          w_paddr_wr;
   logic          w_phi_wr;
   logic          w_plo_wr;
   logic          w_busy;
   logic          w_err;
   logic          w_to_hit;
   logic          w_clr_run;
   logic          w_lat;
   logic          w_unused;

   assign w_acc = wb_stb_i & wb_cyc_i & ~r_wb_ack &
                  (wb_addr_i[31:24] == COPPER_BASE);
   assign w_wr       = w_acc & wb_we_i;
   assign w_off      = wb_addr_i[7:0];
   assign w_ctrl_wr  = w_wr & (w_off == REG_CTRL);
   assign w_paddr_wr = w_wr & (w_off == REG_PADDR);
   assign w_phi_wr   = w_wr & (w_off == REG_PHI);
   assign w_plo_wr   = w_wr & (w_off == REG_PLO);
   assign w_busy     = (r_state != ST_IDLE);
   assign w_pc8      = 8'(r_pc);
   assign w_unused   = ^{wb_sel_i, wb_addr_i[23:8]};

   // slave read mux; unmapped and write-only offsets read as zero
   always_comb begin
      w_rdata = '0;
      case (w_off)
         REG_CTRL:   w_rdata = {30'b0, r_loop, r_run};
         REG_STATUS: w_rdata = {15'b0, w_err, 7'b0, w_busy, w_pc8};
         REG_PADDR:  w_rdata = 32'(r_paddr);
         default:    w_rdata = '0;
      endcase
   end

   // registered slave ack (single cycle, gapped) and read data
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wb_ack  <= 1'b0;
         r_wb_data <= '0;
      end else begin
         r_wb_ack <= w_acc;
         if (w_acc && !wb_we_i) r_wb_data <= w_rdata;
      end
   end

   // control registers, program pointer and staging word
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_run   <= 1'b0;
         r_loop  <= 1'b0;
         r_start <= 1'b0;
         r_paddr <= '0;
         r_phi   <= '0;
      end else begin
         r_start <= w_ctrl_wr & wb_data_i[0] & ~r_run;
         if (w_ctrl_wr) begin
            r_run  <= wb_data_i[0];
            r_loop <= wb_data_i[1];
         end else if (w_clr_run) begin
            r_run <= 1'b0;
         end
         if (w_paddr_wr)    r_paddr <= wb_data_i[AW-1:0];
         else if (w_plo_wr) r_paddr <= r_paddr + 1'b1;
         if (w_phi_wr) r_phi <= wb_data_i[7:0];
      end
   end

   vga_copper_ram #(
      .DEPTH (PROG_DEPTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_plo_wr),
      .i_waddr (r_paddr),
      .i_wdata ({r_phi, wb_data_i}),
      .i_re    (r_state == ST_FETCH),
      .i_raddr (r_pc),
      .o_rdata (w_rd)
   );

`ifdef VGA_COPPER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_to_cnt;
   logic          r_err;

   // count unacked bus cycles; flag err when the wait is abandoned
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_to_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         if (r_state == ST_BUS && !m_ack_i) r_to_cnt <= r_to_cnt + 1'b1;
         else r_to_cnt <= '0;
         if (r_start)       r_err <= 1'b0;
         else if (w_to_hit) r_err <= 1'b1;
      end
   end

   assign w_to_hit = (r_state == ST_BUS) && !m_ack_i &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign w_err    = r_err;
`else
   logic w_unused_to;

   assign w_to_hit    = 1'b0;
   assign w_err       = 1'b0;
   assign w_unused_to = (TIMEOUT_CYCLES == 0);
`endif

   // sequencer state and program counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // next-state decode; clearing run from the CPU overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_clr_run   = 1'b0;
      w_lat       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (r_start) begin
               w_pc_nxt    = '0;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: w_state_nxt = ST_EXEC;
         ST_EXEC: begin
            unique case (w_rd[39:38])
               OP_WRITE: begin
                  w_lat       = 1'b1;
                  w_state_nxt = ST_BUS;
               end
               OP_NOP: begin
                  w_pc_nxt    = r_pc + 1'b1;
                  w_state_nxt = ST_FETCH;
               end
               OP_JUMP: begin
                  w_pc_nxt    = w_rd[AW-1:0];
                  w_state_nxt = ST_FETCH;
               end
               OP_END: begin
                  if (r_loop) begin
                     w_pc_nxt    = '0;
                     w_state_nxt = ST_FETCH;
                  end else begin
                     w_clr_run   = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end
            endcase
         end
         ST_BUS: begin
            if (m_ack_i) begin
               w_pc_nxt    = r_pc + 1'b1;
               w_state_nxt = ST_FETCH;
            end else if (w_to_hit) begin
               w_clr_run   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
      endcase
      if (r_state != ST_IDLE && !r_run) begin
         w_pc_nxt    = '0;
         w_state_nxt = ST_IDLE;
      end
   end

   // capture the write target when the WRITE entry is decoded
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_m_off  <= '0;
         r_m_data <= '0;
      end else if (w_lat) begin
         r_m_off  <= w_rd[37:32];
         r_m_data <= w_rd[31:0];
      end
   end

   assign wb_ack_o  = r_wb_ack;
   assign wb_data_o = r_wb_data;
   assign m_stb_o   = (r_state == ST_BUS);
   assign m_cyc_o   = m_stb_o;
   assign m_we_o    = m_stb_o;
   assign m_sel_o   = {4{m_stb_o}};
   assign m_addr_o  = m_stb_o ?
                      {VGA_CORE_BASE, 16'h0000, 2'b00, r_m_off} : '0;
   assign m_data_o  = m_stb_o ? r_m_data : '0;

endmodule

// File: tb/tb_vga_copper.sv
// Directed bench for vga_copper with a master-side scoreboard.
// Honours VGA_COPPER_TIMEOUT_EN to pick the bus-wait expectation.
module tb_vga_copper;
   import vga_copper_pkg::*;

   localparam logic [31:0] CB = 32'h0500_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wb_addr_i;
   logic [31:0] wb_data_i;
   logic [31:0] wb_data_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_ack_o;
   logic [31:0] m_addr_o;
   logic [31:0] m_data_o;
   logic [3:0]  m_sel_o;
   logic        m_we_o;
   logic        m_stb_o;
   logic        m_cyc_o;
   logic        m_ack_i;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      int          len;
      bit          stable;
   } txn_t;

   txn_t        obs_q[$];
   logic [63:0] exp_q[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          ack_delay = 1;
   int          stb_cnt = 0;
   logic [31:0] a0;
   logic [31:0] d0;
   bit          stab;

   vga_copper #(
      .PROG_DEPTH     (64),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wb_addr_i (wb_addr_i),
      .wb_data_i (wb_data_i),
      .wb_data_o (wb_data_o),
      .wb_sel_i  (wb_sel_i),
      .wb_we_i   (wb_we_i),
      .wb_stb_i  (wb_stb_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_ack_o  (wb_ack_o),
      .m_addr_o  (m_addr_o),
      .m_data_o  (m_data_o),
      .m_sel_o   (m_sel_o),
      .m_we_o    (m_we_o),
      .m_stb_o   (m_stb_o),
      .m_cyc_o   (m_cyc_o),
      .m_ack_i   (m_ack_i)
   );

   always #5 clk = ~clk;

   // vga_core model: acks the Nth strobe cycle, logs each strobe burst
   always @(negedge clk) begin
      if (m_stb_o) begin
         if (stb_cnt == 0) begin
            a0   = m_addr_o;
            d0   = m_data_o;
            stab = (m_sel_o == 4'hF) && m_we_o && m_cyc_o;
         end else if (m_addr_o !== a0 || m_data_o !== d0 ||
                      m_sel_o !== 4'hF || !m_we_o || !m_cyc_o) begin
            stab = 1'b0;
         end
         stb_cnt++;
         m_ack_i = (ack_delay != 0) && (stb_cnt == ack_delay);
      end else begin
         if (stb_cnt != 0) obs_q.push_back('{a0, d0, stb_cnt, stab});
         stb_cnt = 0;
         m_ack_i = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wb_xfer(input logic [31:0] a, input logic we,
                          input logic [31:0] d, output logic [31:0] q);
      int n;
      @(posedge clk);
      #1;
      wb_addr_i = a;
      wb_data_i = d;
      wb_we_i   = we;
      wb_stb_i  = 1'b1;
      wb_cyc_i  = 1'b1;
      for (n = 0; n < 10; n++) begin
         @(posedge clk);
         #1;
         if (wb_ack_o) break;
      end
      q        = wb_data_o;
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      wb_we_i  = 1'b0;
      if (n == 10) check("wb_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] q;
      wb_xfer(a, 1'b1, d, q);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
      wb_xfer(a, 1'b0, 32'd0, q);
   endtask

   task automatic prog(input int idx, input logic [1:0] op,
                       input logic [5:0] off, input logic [31:0] d);
      wb_write(CB | 32'(REG_PADDR), 32'(idx));
      wb_write(CB | 32'(REG_PHI), {24'd0, op, off});
      wb_write(CB | 32'(REG_PLO), d);
   endtask

   task automatic expect_wr(input logic [5:0] off, input logic [31:0] d);
      exp_q.push_back({24'h040000, 2'b00, off, d});
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] s;
      int n = 0;
      do begin
         wb_read(CB | 32'(REG_STATUS), s);
         n++;
      end while (s[8] && n < 300);
      check(tag, {31'd0, s[8]}, 32'd0);
   endtask

   task automatic get_txn(input string tag, input int len);
      txn_t        t;
      logic [63:0] e;
      int          n = 0;
      while (obs_q.size() == 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
         check({tag, "_present"}, 32'd0, 32'd1);
      end else begin
         t = obs_q.pop_front();
         e = exp_q.pop_front();
         check({tag, "_addr"}, t.a, e[63:32]);
         check({tag, "_data"}, t.d, e[31:0]);
         check({tag, "_stable"}, {31'd0, t.stable}, 32'd1);
         if (len != 0) check({tag, "_len"}, 32'(t.len), 32'(len));
      end
   endtask

   initial begin
      logic [31:0] q;
      int          lat;

      reset     = 1'b0;
      wb_addr_i = '0;
      wb_data_i = '0;
      wb_sel_i  = 4'hF;
      wb_we_i   = 1'b0;
      wb_stb_i  = 1'b0;
      wb_cyc_i  = 1'b0;
      m_ack_i   = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("rst_stb", {31'd0, m_stb_o}, 32'd0);
      check("rst_cyc", {31'd0, m_cyc_o}, 32'd0);
      check("rst_addr", m_addr_o, 32'd0);
      check("rst_mdata", m_data_o, 32'd0);
      check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
      reset = 1'b1;
      wb_read(CB | 32'(REG_STATUS), q);
      check("rst_status", q, 32'd0);
      wb_read(CB | 32'(REG_CTRL), q);
      check("rst_ctrl", q, 32'd0);
      wb_read(CB | 32'(REG_PADDR), q);
      check("rst_paddr", q, 32'd0);

      wb_write(CB | 32'h40, 32'hFFFF_FFFF);
      wb_read(CB | 32'h40, q);
      check("unmapped", q, 32'd0);

      // single WRITE then END, measure start latency
      ack_delay = 1;
      prog(0, OP_WRITE, 6'h1C, 32'h0000_0F00);
      prog(1, OP_END, 6'h00, 32'd0);
      wb_read(CB | 32'(REG_PADDR), q);
      check("paddr_inc", q, 32'd2);
      expect_wr(6'h1C, 32'h0000_0F00);
      wb_write(CB | 32'(REG_CTRL), 32'd1);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!m_stb_o && lat < 20);
      check("start_lat", 32'(lat), 32'd3);
      wait_idle("t1_idle");
      get_txn("t1", 1);
      check("t1_count", 32'(obs_q.size()), 32'd0);
      wb_read(CB | 32'(REG_CTRL), q);
      check("t1_run_clr", q, 32'd0);

      // slow slave: five-cycle strobe, two writes in order
      ack_delay = 5;
      prog(0, OP_WRITE, 6'h10, 32'hAAAA_5555);
      prog(1, OP_WRITE, 6'h14, 32'h1234_5678);
      prog(2, OP_END, 6'h00, 32'd0);
      expect_wr(6'h10, 32'hAAAA_5555);
      expect_wr(6'h14, 32'h1234_5678);
      wb_write(CB | 32'(REG_CTRL), 32'd1);
      wait_idle("t2_idle");
      get_txn("t2a", 5);
      get_txn("t2b", 5);

      // looping program repeats in order
      ack_delay = 2;
      for (int i = 0; i < 3; i++) begin
         expect_wr(6'h10, 32'hAAAA_5555);
         expect_wr(6'h14, 32'h1234_5678);
      end
      wb_write(CB | 32'(REG_CTRL), 32'd3);
      for (int i = 0; i < 6; i++) get_txn($sformatf("t3_%0d", i), 2);
      wb_write(CB | 32'(REG_CTRL), 32'd0);
      wait_idle("t3_idle");
      repeat (2) @(posedge clk);
      obs_q.delete();

      // JUMP skips entries 1 and 2
      ack_delay = 1;
      prog(0, OP_JUMP, 6'h00, 32'h0000_0003);
      prog(1, OP_WRITE, 6'h08, 32'h0000_0111);
      prog(2, OP_WRITE, 6'h0C, 32'h0000_0222);
      prog(3, OP_WRITE, 6'h20, 32'h0000_DEAD);
      prog(4, OP_END, 6'h00, 32'd0);
      expect_wr(6'h20, 32'h0000_DEAD);
      wb_write(CB | 32'(REG_CTRL), 32'd1);
      wait_idle("t4_idle");
      get_txn("t4", 1);
      repeat (3) @(posedge clk);
      check("t4_count", 32'(obs_q.size()), 32'd0);

      // abort while ack is withheld, then re-run from entry 0
      ack_delay = 0;
      prog(0, OP_WRITE, 6'h18, 32'h0000_0005);
      prog(1, OP_WRITE, 6'h1C, 32'h0000_0006);
      prog(2, OP_END, 6'h00, 32'd0);
      wb_write(CB | 32'(REG_CTRL), 32'd1);
      lat = 0;
      while (!m_stb_o && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("t5_stb_up", {31'd0, m_stb_o}, 32'd1);
      repeat (2) @(posedge clk);
      wb_write(CB | 32'(REG_CTRL), 32'd0);
      @(posedge clk);
      #1;
      check("t5_stb_dn", {31'd0, m_stb_o}, 32'd0);
      check("t5_cyc_dn", {31'd0, m_cyc_o}, 32'd0);
      wb_read(CB | 32'(REG_STATUS), q);
      check("t5_status", q, 32'd0);
      obs_q.delete();
      ack_delay = 1;
      expect_wr(6'h18, 32'h0000_0005);
      expect_wr(6'h1C, 32'h0000_0006);
      wb_write(CB | 32'(REG_CTRL), 32'd1);
      wait_idle("t5_idle");
      get_txn("t5a", 1);
      get_txn("t5b", 1);

      // ack never arrives
      ack_delay = 0;
      wb_write(CB | 32'(REG_CTRL), 32'd1);
`ifdef VGA_COPPER_TIMEOUT_EN
      expect_wr(6'h18, 32'h0000_0005);
      wait_idle("t6_idle");
      get_txn("t6", 16);
      wb_read(CB | 32'(REG_STATUS), q);
      check("t6_err", {31'd0, q[16]}, 32'd1);
      wb_read(CB | 32'(REG_CTRL), q);
      check("t6_run", q, 32'd0);
`else
      repeat (1000) @(posedge clk);
      #1;
      check("t6_stb", {31'd0, m_stb_o}, 32'd1);
      check("t6_long", {31'd0, stb_cnt > 990}, 32'd1);
      wb_read(CB | 32'(REG_STATUS), q);
      check("t6_err", {31'd0, q[16]}, 32'd0);
      wb_write(CB | 32'(REG_CTRL), 32'd0);
      wait_idle("t6_idle");
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
